gemm_group_scheduler: RTL and testbench

//  Descriptor-driven GEMM dispatcher, next generation of the group dispatcher. Buffers up to DESC_DEPTH

---
 rtl/gsch_pkg.sv | 34 +++
 rtl/gsch_desc_fifo.sv | 66 ++++++
 rtl/gemm_group_scheduler.sv | 251 +++++++++++++++++++++++++
 tb/tb_gemm_group_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gsch_pkg.sv
// Shared types and constants for the GEMM group scheduler.
// The descriptor layout is fixed here, so the top checks its parameters against it.
package gsch_pkg;

    localparam int GSCH_SYS    = 16;
    localparam int GSCH_MAX    = 16;
    localparam int GSCH_ADDR_W = 19;
    localparam int GSCH_KB_W   = 6;

    localparam int BEAT_BYTES   = GSCH_SYS * 4;
    localparam int CHUNK_STRIDE = GSCH_MAX * GSCH_SYS * GSCH_SYS * 4;

    typedef struct packed {
        logic [GSCH_KB_W-1:0]   k_blocks;
        logic                   bias_en;
        logic                   relu_en;
        logic                   clear;
        logic                   wb_dis;
        logic [GSCH_ADDR_W-1:0] w_addr;
        logic [GSCH_ADDR_W-1:0] a_addr;
        logic [GSCH_ADDR_W-1:0] b_addr;
        logic [GSCH_ADDR_W-1:0] o_addr;
    } gsch_desc_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_BIAS,
        S_RD_WA,
        S_ACC,
        S_WB
    } gsch_state_e;

endpackage

// File: rtl/gsch_desc_fifo.sv
// Descriptor FIFO with registered full/empty flags.
// Push and pop in the same cycle are both accepted.
import gsch_pkg::*;

module gsch_desc_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  gsch_desc_t in_data_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output gsch_desc_t out_data_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("DESC_DEPTH must be a power of 2 and >= 2");
    end

    gsch_desc_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, empty_q;
    logic          push, pop;

    assign push        = in_valid_i & ~full_q;
    assign pop         = out_ready_i & ~empty_q;
    assign in_ready_o  = ~full_q;
    assign out_valid_o = ~empty_q;
    assign out_data_o  = mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CW'(DEPTH));
            empty_q <= (cnt_d == '0);
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data_i;
    end

endmodule

// File: rtl/gemm_group_scheduler.sv
// GEMM group scheduler: buffers descriptors and walks each K dimension in chunks.
// Defining GSCH_PERF_CNT_EN adds saturating busy-cycle and completed-group counters.
import gsch_pkg::*;

module gemm_group_scheduler #(
    parameter int SYS_ARRAY_SIZE     = 16,
    parameter int ADDRESS_WIDTH      = 19,
    parameter int BLOCK_SIZE_WIDTH   = 6,
    parameter int MAX_CHUNK_BLOCKS   = 16,
    parameter int BURST_LENGTH_WIDTH = 8,
    parameter int BURST_SIZE_WIDTH   = 3,
    parameter int DESC_DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          desc_valid,
    output logic                          desc_ready,
    input  gsch_desc_t                    desc_data,
    input  logic                          gemm_ready,
    input  logic                          acc_valid,
    output logic                          start_op,
    output logic                          clear_buffer,
    output logic                          relu_en,
    output logic [BLOCK_SIZE_WIDTH-1:0]   block_size,
    output logic                          bias_read_valid,
    output logic                          rd0_cmd_valid,
    input  logic                          rd0_cmd_ready,
    output logic [ADDRESS_WIDTH-1:0]      rd0_cmd_addr,
    output logic [BURST_LENGTH_WIDTH-1:0] rd0_cmd_len,
    input  logic                          rd0_done,
    output logic                          rd1_cmd_valid,
    input  logic                          rd1_cmd_ready,
    output logic [ADDRESS_WIDTH-1:0]      rd1_cmd_addr,
    output logic [BURST_LENGTH_WIDTH-1:0] rd1_cmd_len,
    input  logic                          rd1_done,
    output logic                          wr_cmd_valid,
    input  logic                          wr_cmd_ready,
    output logic [ADDRESS_WIDTH-1:0]      wr_cmd_addr,
    output logic [BURST_LENGTH_WIDTH-1:0] wr_cmd_len,
    input  logic                          wr_done,
    output logic [BURST_SIZE_WIDTH-1:0]   burst_size,
    output logic                          desc_drop,
`ifdef GSCH_PERF_CNT_EN
    output logic                          gemm_idle,
    output logic [31:0]                   perf_busy_cycles,
    output logic [15:0]                   perf_groups
`else
    output logic                          gemm_idle
`endif
);

    localparam logic [BLOCK_SIZE_WIDTH-1:0] MAX_BS =
        BLOCK_SIZE_WIDTH'(MAX_CHUNK_BLOCKS);
    localparam logic [ADDRESS_WIDTH-1:0] STRIDE =
        ADDRESS_WIDTH'(MAX_CHUNK_BLOCKS * SYS_ARRAY_SIZE * SYS_ARRAY_SIZE * 4);
    localparam logic [BURST_LENGTH_WIDTH-1:0] BEAT_LEN =
        BURST_LENGTH_WIDTH'(SYS_ARRAY_SIZE - 1);

    if (MAX_CHUNK_BLOCKS * SYS_ARRAY_SIZE > 2 ** BURST_LENGTH_WIDTH) begin : g_len_chk
        $error("chunk burst does not fit BURST_LENGTH_WIDTH");
    end
    if (ADDRESS_WIDTH != GSCH_ADDR_W || BLOCK_SIZE_WIDTH != GSCH_KB_W ||
        SYS_ARRAY_SIZE * 4 != BEAT_BYTES ||
        MAX_CHUNK_BLOCKS * SYS_ARRAY_SIZE * SYS_ARRAY_SIZE * 4 != CHUNK_STRIDE) begin : g_pkg_chk
        $error("parameters disagree with gsch_pkg descriptor layout");
    end

    gsch_state_e                   state_q;
    gsch_desc_t                    desc_q, fifo_head;
    logic                          fifo_valid, fifo_full_n, fifo_pop;
    logic [BLOCK_SIZE_WIDTH-1:0]   rem_q, next_rem, bs_next, bs_q;
    logic [ADDRESS_WIDTH-1:0]      off_q, next_off;
    logic                          first_q, done0_q, done1_q;
    logic                          last_chunk, rdwa_enter;
    logic                          start_q, clear_q, relu_q, bias_rv_q, drop_q;
    logic                          rd0_v_q, rd1_v_q, wr_v_q;
    logic [ADDRESS_WIDTH-1:0]      rd0_addr_q, rd1_addr_q, wr_addr_q;
    logic [BURST_LENGTH_WIDTH-1:0] rd0_len_q, rd1_len_q, wr_len_q, rdwa_len;

    gsch_desc_fifo #(.DEPTH(DESC_DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (desc_valid),
        .in_ready_o  (fifo_full_n),
        .in_data_i   (desc_data),
        .out_valid_o (fifo_valid),
        .out_ready_i (fifo_pop),
        .out_data_o  (fifo_head)
    );

    assign fifo_pop   = (state_q == S_IDLE) & fifo_valid & gemm_ready;
    assign last_chunk = (rem_q <= MAX_BS);

    // Entry into RD_WA from ACC already uses the advanced chunk position.
    assign next_rem = (state_q == S_ACC) ? rem_q - MAX_BS : rem_q;
    assign next_off = (state_q == S_ACC) ? off_q + STRIDE : off_q;
    assign bs_next  = (next_rem > MAX_BS) ? MAX_BS : next_rem;
    assign rdwa_len = BURST_LENGTH_WIDTH'(int'(bs_next) * SYS_ARRAY_SIZE - 1);

    assign rdwa_enter =
        ((state_q == S_FETCH) && (desc_q.k_blocks != '0) && !desc_q.bias_en) ||
        ((state_q == S_BIAS) && rd0_done) ||
        ((state_q == S_ACC) && acc_valid && !last_chunk);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            desc_q     <= '0;
            rem_q      <= '0;
            off_q      <= '0;
            first_q    <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            start_q    <= 1'b0;
            clear_q    <= 1'b0;
            relu_q     <= 1'b0;
            bias_rv_q  <= 1'b0;
            drop_q     <= 1'b0;
            bs_q       <= '0;
            rd0_v_q    <= 1'b0;
            rd1_v_q    <= 1'b0;
            wr_v_q     <= 1'b0;
            rd0_addr_q <= '0;
            rd1_addr_q <= '0;
            wr_addr_q  <= '0;
            rd0_len_q  <= '0;
            rd1_len_q  <= '0;
            wr_len_q   <= '0;
        end else begin
            start_q <= 1'b0;
            clear_q <= 1'b0;
            drop_q  <= 1'b0;
            if (rd0_v_q && rd0_cmd_ready) rd0_v_q <= 1'b0;
            if (rd1_v_q && rd1_cmd_ready) rd1_v_q <= 1'b0;
            if (wr_v_q && wr_cmd_ready)   wr_v_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (fifo_pop) begin
                        state_q <= S_FETCH;
                        desc_q  <= fifo_head;
                        rem_q   <= fifo_head.k_blocks;
                        off_q   <= '0;
                        first_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    relu_q <= desc_q.relu_en;
                    if (desc_q.k_blocks == '0) begin
                        drop_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (desc_q.bias_en) begin
                        state_q    <= S_BIAS;
                        bias_rv_q  <= 1'b1;
                        rd0_v_q    <= 1'b1;
                        rd0_addr_q <= desc_q.b_addr;
                        rd0_len_q  <= BEAT_LEN;
                    end
                end
                S_BIAS: begin
                    if (rd0_done) bias_rv_q <= 1'b0;
                end
                S_RD_WA: begin
                    if ((done0_q || rd0_done) && (done1_q || rd1_done)) begin
                        state_q <= S_ACC;
                        done0_q <= 1'b0;
                        done1_q <= 1'b0;
                    end else begin
                        done0_q <= done0_q | rd0_done;
                        done1_q <= done1_q | rd1_done;
                    end
                end
                S_ACC: begin
                    if (acc_valid) begin
                        if (last_chunk && desc_q.wb_dis) begin
                            state_q <= S_IDLE;
                        end else if (last_chunk) begin
                            state_q   <= S_WB;
                            wr_v_q    <= 1'b1;
                            wr_addr_q <= desc_q.o_addr;
                            wr_len_q  <= BEAT_LEN;
                        end else begin
                            rem_q <= next_rem;
                            off_q <= next_off;
                        end
                    end
                end
                S_WB: begin
                    if (wr_done) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
            if (rdwa_enter) begin
                state_q    <= S_RD_WA;
                rd0_v_q    <= 1'b1;
                rd1_v_q    <= 1'b1;
                rd0_addr_q <= desc_q.w_addr + next_off;
                rd1_addr_q <= desc_q.a_addr + next_off;
                rd0_len_q  <= rdwa_len;
                rd1_len_q  <= rdwa_len;
                bs_q       <= bs_next;
                start_q    <= 1'b1;
                clear_q    <= desc_q.clear & first_q;
                first_q    <= 1'b0;
                done0_q    <= 1'b0;
                done1_q    <= 1'b0;
            end
        end
    end

    assign desc_ready      = fifo_full_n;
    assign gemm_idle       = (state_q == S_IDLE) & ~fifo_valid;
    assign start_op        = start_q;
    assign clear_buffer    = clear_q;
    assign relu_en         = relu_q;
    assign block_size      = bs_q;
    assign bias_read_valid = bias_rv_q;
    assign desc_drop       = drop_q;
    assign rd0_cmd_valid   = rd0_v_q;
    assign rd0_cmd_addr    = rd0_addr_q;
    assign rd0_cmd_len     = rd0_len_q;
    assign rd1_cmd_valid   = rd1_v_q;
    assign rd1_cmd_addr    = rd1_addr_q;
    assign rd1_cmd_len     = rd1_len_q;
    assign wr_cmd_valid    = wr_v_q;
    assign wr_cmd_addr     = wr_addr_q;
    assign wr_cmd_len      = wr_len_q;
    assign burst_size      = BURST_SIZE_WIDTH'($clog2(SYS_ARRAY_SIZE * 4));

`ifdef GSCH_PERF_CNT_EN
    logic [31:0] busy_q;
    logic [15:0] groups_q;
    logic        group_done;

    assign group_done = ((state_q == S_ACC) && acc_valid && last_chunk && desc_q.wb_dis) ||
                        ((state_q == S_WB) && wr_done);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q   <= '0;
            groups_q <= '0;
        end else begin
            if ((state_q != S_IDLE) && (busy_q != '1)) busy_q <= busy_q + 32'd1;
            if (group_done && (groups_q != '1)) groups_q <= groups_q + 16'd1;
        end
    end

    assign perf_busy_cycles = busy_q;
    assign perf_groups      = groups_q;
`endif

endmodule

// File: tb/tb_gemm_group_scheduler.sv
// Self-checking bench for gemm_group_scheduler: directed and random descriptors
// compared against a chunk-arithmetic reference model.
`timescale 1ns/1ps
module tb_gemm_group_scheduler;
    import gsch_pkg::*;

    localparam int MAXB = 16;
    localparam int SAS  = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       desc_valid, desc_ready;
    gsch_desc_t desc_data;
    logic       gemm_ready, acc_valid;
    logic       start_op, clear_buffer, relu_en, bias_read_valid;
    logic [5:0] block_size;
    logic       rd0_cmd_valid, rd0_cmd_ready, rd0_done;
    logic       rd1_cmd_valid, rd1_cmd_ready, rd1_done;
    logic       wr_cmd_valid, wr_cmd_ready, wr_done;
    logic [18:0] rd0_cmd_addr, rd1_cmd_addr, wr_cmd_addr;
    logic [7:0]  rd0_cmd_len, rd1_cmd_len, wr_cmd_len;
    logic [2:0]  burst_size;
    logic        desc_drop, gemm_idle;
`ifdef GSCH_PERF_CNT_EN
    logic [31:0] perf_busy_cycles;
    logic [15:0] perf_groups;
`endif

    always #5 clk = ~clk;

    gemm_group_scheduler dut (
        .clk(clk), .reset(reset),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_data(desc_data),
        .gemm_ready(gemm_ready), .acc_valid(acc_valid),
        .start_op(start_op), .clear_buffer(clear_buffer), .relu_en(relu_en),
        .block_size(block_size), .bias_read_valid(bias_read_valid),
        .rd0_cmd_valid(rd0_cmd_valid), .rd0_cmd_ready(rd0_cmd_ready),
        .rd0_cmd_addr(rd0_cmd_addr), .rd0_cmd_len(rd0_cmd_len), .rd0_done(rd0_done),
        .rd1_cmd_valid(rd1_cmd_valid), .rd1_cmd_ready(rd1_cmd_ready),
        .rd1_cmd_addr(rd1_cmd_addr), .rd1_cmd_len(rd1_cmd_len), .rd1_done(rd1_done),
        .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
        .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len), .wr_done(wr_done),
        .burst_size(burst_size), .desc_drop(desc_drop),
`ifdef GSCH_PERF_CNT_EN
        .gemm_idle(gemm_idle),
        .perf_busy_cycles(perf_busy_cycles), .perf_groups(perf_groups)
`else
        .gemm_idle(gemm_idle)
`endif
    );

    int total = 0, passed = 0;
    int n_start = 0, n_clear = 0, n_drop = 0, n_vcyc = 0;
    int n_hs0 = 0, n_hs1 = 0, n_hsw = 0;

    always @(negedge clk) begin
        if (start_op) n_start++;
        if (clear_buffer) n_clear++;
        if (desc_drop) n_drop++;
        if (rd0_cmd_valid && rd0_cmd_ready) n_hs0++;
        if (rd1_cmd_valid && rd1_cmd_ready) n_hs1++;
        if (wr_cmd_valid && wr_cmd_ready) n_hsw++;
        if (rd0_cmd_valid || rd1_cmd_valid || wr_cmd_valid) n_vcyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic vld(input int ch);
        case (ch)
            0: return rd0_cmd_valid;
            1: return rd1_cmd_valid;
            default: return wr_cmd_valid;
        endcase
    endfunction

    task automatic set_rdy(input int ch, input logic v);
        case (ch)
            0: rd0_cmd_ready = v;
            1: rd1_cmd_ready = v;
            default: wr_cmd_ready = v;
        endcase
    endtask

    task automatic wait_vld(input int ch, input string tag);
        int t = 0;
        while (!vld(ch) && t < 60) begin
            tick();
            t++;
        end
        chk(tag, vld(ch), 1);
    endtask

    task automatic hs(input int ch, input string tag);
        int d = $urandom_range(0, 2);
        repeat (d) begin
            tick();
            chk({tag, "_hold"}, vld(ch), 1);
        end
        set_rdy(ch, 1'b1);
        tick();
        set_rdy(ch, 1'b0);
        chk({tag, "_fall"}, vld(ch), 0);
    endtask

    // Reference: K split into ceil(k/MAX) chunks, last one takes the remainder.
    function automatic int model_bs(input int k, input int p);
        int n = (k + MAXB - 1) / MAXB;
        if (p < n - 1) return MAXB;
        return (k % MAXB == 0) ? MAXB : k % MAXB;
    endfunction

    function automatic int wrap(input int base, input int p);
        return (base + p * MAXB * SAS * SAS * 4) % (1 << 19);
    endfunction

    function automatic gsch_desc_t rnd_desc(input int k);
        gsch_desc_t d;
        d.k_blocks = 6'(k);
        d.bias_en  = 1'($urandom_range(0, 1));
        d.relu_en  = 1'($urandom_range(0, 1));
        d.clear    = 1'($urandom_range(0, 1));
        d.wb_dis   = 1'($urandom_range(0, 1));
        d.w_addr   = 19'($urandom);
        d.a_addr   = 19'($urandom);
        d.b_addr   = 19'($urandom);
        d.o_addr   = 19'($urandom);
        return d;
    endfunction

    task automatic push(input gsch_desc_t d);
        desc_valid = 1'b1;
        desc_data  = d;
        tick();
        desc_valid = 1'b0;
    endtask

    task automatic run_desc(input gsch_desc_t d, input bit expect_idle);
        int k = int'(d.k_blocks);
        int n = (k + MAXB - 1) / MAXB;
        int s0 = n_start, c0 = n_clear, h0 = n_hs0, h1 = n_hs1, hw = n_hsw;
        if (d.bias_en) begin
            wait_vld(0, "bias_v");
            chk("bias_rv", bias_read_valid, 1);
            chk("bias_addr", rd0_cmd_addr, d.b_addr);
            chk("bias_len", rd0_cmd_len, SAS - 1);
            hs(0, "bias");
            rd0_done = 1'b1;
            tick();
            rd0_done = 1'b0;
            chk("bias_rv_off", bias_read_valid, 0);
        end
        for (int p = 0; p < n; p++) begin
            int bs = model_bs(k, p);
            int mode;
            wait_vld(0, "rdwa_v0");
            chk("rdwa_v1", rd1_cmd_valid, 1);
            chk("no_early_wb", wr_cmd_valid, 0);
            chk("block_size", block_size, bs);
            chk("rd0_addr", rd0_cmd_addr, wrap(int'(d.w_addr), p));
            chk("rd1_addr", rd1_cmd_addr, wrap(int'(d.a_addr), p));
            chk("rd0_len", rd0_cmd_len, bs * SAS - 1);
            chk("rd1_len", rd1_cmd_len, bs * SAS - 1);
            chk("relu_en", relu_en, d.relu_en);
            if ($urandom_range(0, 1) == 1) begin
                hs(0, "rd0");
                hs(1, "rd1");
            end else begin
                hs(1, "rd1");
                hs(0, "rd0");
            end
            mode = $urandom_range(0, 2);
            if (mode == 2) begin
                rd0_done = 1'b1;
                rd1_done = 1'b1;
                tick();
                rd0_done = 1'b0;
                rd1_done = 1'b0;
            end else begin
                if (mode == 0) rd0_done = 1'b1; else rd1_done = 1'b1;
                tick();
                rd0_done = 1'b0;
                rd1_done = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
                if (mode == 0) rd1_done = 1'b1; else rd0_done = 1'b1;
                tick();
                rd0_done = 1'b0;
                rd1_done = 1'b0;
            end
            repeat ($urandom_range(0, 2)) tick();
            acc_valid = 1'b1;
            tick();
            acc_valid = 1'b0;
        end
        if (!d.wb_dis) begin
            wait_vld(2, "wb_v");
            chk("wb_addr", wr_cmd_addr, d.o_addr);
            chk("wb_len", wr_cmd_len, SAS - 1);
            hs(2, "wb");
            wr_done = 1'b1;
            tick();
            wr_done = 1'b0;
        end
        chk("start_cnt", n_start - s0, n);
        chk("clear_cnt", n_clear - c0, d.clear ? 1 : 0);
        chk("rd0_cmds", n_hs0 - h0, n + (d.bias_en ? 1 : 0));
        chk("rd1_cmds", n_hs1 - h1, n);
        chk("wr_cmds", n_hsw - hw, d.wb_dis ? 0 : 1);
        if (expect_idle) chk("idle_after", gemm_idle, 1);
    endtask

    initial begin
        gsch_desc_t d;
        gsch_desc_t q[$];
        int v0, dr0;
        reset = 1'b0;
        desc_valid = 1'b0;
        desc_data = '0;
        gemm_ready = 1'b0;
        acc_valid = 1'b0;
        rd0_cmd_ready = 1'b0;
        rd1_cmd_ready = 1'b0;
        wr_cmd_ready = 1'b0;
        rd0_done = 1'b0;
        rd1_done = 1'b0;
        wr_done = 1'b0;
        tick();
        tick();
        chk("rst_desc_ready", desc_ready, 1);
        chk("rst_idle", gemm_idle, 1);
        chk("rst_valids", {rd0_cmd_valid, rd1_cmd_valid, wr_cmd_valid}, 0);
        chk("rst_pulses", {start_op, clear_buffer, desc_drop}, 0);
        chk("rst_bs", block_size, 0);
        chk("rst_relu_bias", {relu_en, bias_read_valid}, 0);
        chk("burst_size", burst_size, 6);
        reset = 1'b1;
        tick();
        gemm_ready = 1'b1;

        d = rnd_desc(5);
        d.bias_en = 1'b0;
        d.wb_dis = 1'b0;
        push(d);
        run_desc(d, 1);

        d = rnd_desc(40);
        d.w_addr = 19'h7C000;
        d.wb_dis = 1'b0;
        d.clear = 1'b1;
        push(d);
        run_desc(d, 1);

        d = rnd_desc(32);
        d.clear = 1'b1;
        push(d);
        run_desc(d, 1);

        v0 = n_vcyc;
        dr0 = n_drop;
        d = rnd_desc(0);
        push(d);
        tick();
        tick();
        chk("drop_idle", gemm_idle, 1);
        tick();
        chk("drop_pulse", n_drop - dr0, 1);
        chk("drop_no_cmd", n_vcyc - v0, 0);

        gemm_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            q.push_back(rnd_desc($urandom_range(1, 63)));
            desc_valid = 1'b1;
            desc_data = q[i];
            tick();
            chk("fifo_ready", desc_ready, (i < 3) ? 1 : 0);
        end
        desc_valid = 1'b0;
        chk("fifo_busy", gemm_idle, 0);
        repeat (3) tick();
        chk("fifo_hold", n_vcyc - v0, 0);
        gemm_ready = 1'b1;
        for (int i = 0; i < 4; i++) run_desc(q[i], i == 3);

        for (int i = 0; i < 14; i++) begin
            d = rnd_desc($urandom_range(1, 63));
            push(d);
            run_desc(d, 1);
        end

        d = rnd_desc(20);
        d.bias_en = 1'b0;
        push(d);
        wait_vld(0, "mid_v");
        reset = 1'b0;
        #1;
        chk("mid_valids", {rd0_cmd_valid, rd1_cmd_valid, wr_cmd_valid}, 0);
        chk("mid_idle", gemm_idle, 1);
        chk("mid_bs", block_size, 0);
        chk("mid_ready", desc_ready, 1);
        tick();
        reset = 1'b1;
        tick();
        d = rnd_desc(17);
        push(d);
        run_desc(d, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
